// File: rtl/seq_div9.sv
// seq_div9: multi-cycle restoring divider, MSB-first, one quotient bit per clock.
// Valid/ready handshakes on both sides; a zero divisor short-circuits to DONE.
module seq_div9 #(
   parameter int WIDTH = 9,
   parameter int DIVW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   input  logic [DIVW-1:0]  divisor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [DIVW-1:0]  remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DIVW-1:0]  prem_q, prem_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [DIVW-1:0]  dvs_q, dvs_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [DIVW-1:0]  rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   // Partial remainder after the shift needs DIVW+1 bits; the restored
   // value is always below the divisor, so only DIVW bits are stored.
   logic [DIVW:0]    shifted, trial;
   logic             fits, last;

   always_comb begin
      shifted = {prem_q, dvd_q[WIDTH-1]};
      trial   = shifted - {1'b0, dvs_q};
      fits    = shifted >= {1'b0, dvs_q};
      last    = cnt_q == CW'(WIDTH - 1);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
         CALC: if (last)     state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cnt_d  = cnt_q;
      prem_d = prem_q;
      dvd_d  = dvd_q;
      dvs_d  = dvs_q;
      if (state_q == IDLE && in_valid) begin
         cnt_d  = '0;
         prem_d = '0;
         dvd_d  = dividend;
         dvs_d  = divisor;
      end else if (state_q == CALC) begin
         cnt_d  = cnt_q + 1'b1;
         prem_d = fits ? trial[DIVW-1:0] : shifted[DIVW-1:0];
         dvd_d  = {dvd_q[WIDTH-2:0], fits};
      end
   end

   always_comb begin
      quot_d      = quot_q;
      rem_d       = rem_q;
      dbz_d       = dbz_q;
      in_ready_d  = state_d == IDLE;
      out_valid_d = state_d == DONE;
      if (state_q == IDLE && in_valid) begin
         if (divisor == '0) begin
            quot_d = '1;
            rem_d  = DIVW'(dividend);
            dbz_d  = 1'b1;
         end else begin
            dbz_d  = 1'b0;
         end
      end else if (state_q == CALC && last) begin
         quot_d = {dvd_q[WIDTH-2:0], fits};
         rem_d  = fits ? trial[DIVW-1:0] : shifted[DIVW-1:0];
         dbz_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         prem_q      <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         quot_q      <= '0;
         rem_q       <= '0;
         dbz_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         prem_q      <= prem_d;
         dvd_q       <= dvd_d;
         dvs_q       <= dvs_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dbz_q       <= dbz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div9.sv
// tb_seq_div9: directed and randomized checks of seq_div9 against an
// arithmetic reference model (a/b, a%b, zero-divisor rule).
module tb_seq_div9;

   localparam int W = 9;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] dividend = '0;
   logic [D-1:0] divisor = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] quotient;
   logic [D-1:0] remainder;
   logic         div_by_zero;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_div9 #(.WIDTH(W), .DIVW(D)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(input int a, input int b,
                                 output logic [W-1:0] q,
                                 output logic [D-1:0] r,
                                 output logic z, output int lat);
      if (b == 0) begin
         q = W'((1 << W) - 1);
         r = D'(a % (1 << D));
         z = 1'b1;
         lat = 0;
      end else begin
         q = W'(a / b);
         r = D'(a % b);
         z = 1'b0;
         lat = W;
      end
   endfunction

   // Runs one transaction; reports latency (edges after the accepting edge)
   // and the observed result. Comparisons are made by the callers.
   task automatic do_op(input int a, input int b, input int stall,
                        output int lat, output logic [W-1:0] q,
                        output logic [D-1:0] r, output logic z,
                        output bit tmo);
      tmo = 1'b0;
      lat = 0;
      q = '0;
      r = '0;
      z = 1'b0;
      for (int i = 0; i < 50 && !in_ready; i++) step();
      if (!in_ready) begin
         tmo = 1'b1;
         return;
      end
      in_valid = 1'b1;
      dividend = W'(a);
      divisor  = D'(b);
      step();
      in_valid = 1'b0;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      if (!out_valid) begin
         tmo = 1'b1;
         return;
      end
      q = quotient;
      r = remainder;
      z = div_by_zero;
      repeat (stall) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero} !==
          {1'b1, 1'b0, W'(0), D'(0), 1'b0}) begin
         n_fail++;
         $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
   endtask

   task automatic test_basic();
      int lat;
      logic [W-1:0] q, eq;
      logic [D-1:0] r, er;
      logic z, ez;
      int elat;
      bit tmo;
      model(500, 7, eq, er, ez, elat);
      do_op(500, 7, 0, lat, q, r, z, tmo);
      n_cmp++;
      if (tmo !== 1'b0 || lat !== elat) begin
         n_fail++;
         $display("FAIL basic_lat: got %0d tmo=%b want %0d", lat, tmo, elat);
      end
      n_cmp++;
      if ({q, r, z} !== {eq, er, ez}) begin
         n_fail++;
         $display("FAIL basic_res: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
                  q, r, z, eq, er, ez);
      end
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_turn: got rdy=%b vld=%b want 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_boundary();
      int as[5] = '{511, 5, 0, 256, 255};
      int bs[5] = '{255, 9, 1, 1, 255};
      int lat, elat;
      logic [W-1:0] q, eq;
      logic [D-1:0] r, er;
      logic z, ez;
      bit tmo;
      for (int i = 0; i < 5; i++) begin
         model(as[i], bs[i], eq, er, ez, elat);
         do_op(as[i], bs[i], i % 2, lat, q, r, z, tmo);
         n_cmp++;
         if (tmo || {q, r, z} !== {eq, er, ez} || lat !== elat) begin
            n_fail++;
            $display("FAIL boundary %0d/%0d: got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                     as[i], bs[i], q, r, z, lat, eq, er, ez, elat);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat;
      logic [W-1:0] q;
      logic [D-1:0] r;
      logic z;
      bit tmo;
      do_op(300, 0, 2, lat, q, r, z, tmo);
      n_cmp++;
      if (tmo || lat !== 0) begin
         n_fail++;
         $display("FAIL dz_lat: got %0d tmo=%b want 0 further edges", lat, tmo);
      end
      n_cmp++;
      if ({q, r, z} !== {W'(511), D'(44), 1'b1}) begin
         n_fail++;
         $display("FAIL dz_res: got q=%0d r=%0d z=%b want 511 44 1", q, r, z);
      end
      do_op(10, 3, 0, lat, q, r, z, tmo);
      n_cmp++;
      if (tmo || {q, r, z} !== {W'(3), D'(1), 1'b0}) begin
         n_fail++;
         $display("FAIL dz_next: got q=%0d r=%0d z=%b want 3 1 0", q, r, z);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      bit bad;
      in_valid = 1'b1;
      dividend = W'(100);
      divisor  = D'(10);
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      n_cmp++;
      if (!out_valid) begin
         n_fail++;
         $display("FAIL bp_wait: got out_valid=%b want 1", out_valid);
      end
      in_valid = 1'b1;
      dividend = W'(50);
      divisor  = D'(7);
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if ({out_valid, in_ready, quotient, remainder} !==
             {1'b1, 1'b0, W'(10), D'(0)}) bad = 1'b1;
      end
      n_cmp++;
      if (bad) begin
         n_fail++;
         $display("FAIL bp_hold: got vld=%b rdy=%b q=%0d r=%0d want 1 0 10 0",
                  out_valid, in_ready, quotient, remainder);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hs: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      step();
      in_valid = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_accept: got rdy=%b want 0", in_ready);
      end
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      n_cmp++;
      if ({out_valid, quotient, remainder} !== {1'b1, W'(7), D'(1)} || n !== W) begin
         n_fail++;
         $display("FAIL bp_pending: got vld=%b q=%0d r=%0d lat=%0d want 1 7 1 %0d",
                  out_valid, quotient, remainder, n, W);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [W-1:0] q;
      logic [D-1:0] r;
      logic z;
      bit tmo, seen;
      in_valid = 1'b1;
      dividend = W'(400);
      divisor  = D'(3);
      step();
      in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero} !==
          {1'b1, 1'b0, W'(0), D'(0), 1'b0}) begin
         n_fail++;
         $display("FAIL mid_rst: rdy=%b vld=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero);
      end
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_fail++;
         $display("FAIL mid_drop: got out_valid=1 want none");
      end
      do_op(400, 3, 1, lat, q, r, z, tmo);
      n_cmp++;
      if (tmo || {q, r, z} !== {W'(133), D'(1), 1'b0}) begin
         n_fail++;
         $display("FAIL mid_fresh: got q=%0d r=%0d z=%b want 133 1 0", q, r, z);
      end
   endtask

   task automatic test_random();
      int a, b, lat, elat;
      logic [W-1:0] q, eq;
      logic [D-1:0] r, er;
      logic z, ez;
      bit tmo;
      for (int i = 0; i < 2000; i++) begin
         a = int'($urandom_range(0, (1 << W) - 1));
         case ($urandom_range(0, 9))
            0: b = 0;
            1: b = (1 << D) - 1;
            2, 3: b = int'($urandom_range(1, 15));
            default: b = int'($urandom_range(0, (1 << D) - 1));
         endcase
         model(a, b, eq, er, ez, elat);
         do_op(a, b, int'($urandom_range(0, 3)), lat, q, r, z, tmo);
         n_cmp++;
         if (tmo || {q, r, z} !== {eq, er, ez} || lat !== elat) begin
            n_fail++;
            $display("FAIL rand %0d/%0d: got q=%0d r=%0d z=%b lat=%0d want q=%0d r=%0d z=%b lat=%0d",
                     a, b, q, r, z, lat, eq, er, ez, elat);
         end
         if (b != 0) begin
            n_cmp++;
            if (int'(q) * b + int'(r) != a || int'(r) >= b) begin
               n_fail++;
               $display("FAIL rand_inv %0d/%0d: got q=%0d r=%0d", a, b, q, r);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundary();
      test_div_zero();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_div9.md
Name: seq_div9

Overview:
- Multi-cycle restoring divider; the inverse-direction companion of the team's registered add/sub datapath.
- Takes a WIDTH-bit dividend (e.g. a 9-bit carry-extended sum) and a DIVW-bit divisor.
- Returns quotient and remainder through valid/ready handshakes on both sides.
- Sits downstream of the arithmetic result registers, e.g. for averaging or scaling of sums.

Parameters:
- WIDTH, 9, dividend and quotient width in bits (≥2).
- DIVW, 8, divisor and remainder width in bits (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- dividend  input  WIDTH  unsigned dividend.
- divisor  input  DIVW  unsigned divisor.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  DIVW  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Interface:
  - One clock `clk`.
  - Reset `rst` is synchronous and active-high.
  - All outputs are registered.
- Reset (`rst`=1 at an edge):
  - state=IDLE; in_ready=1 after reset.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and partial remainder cleared.
  - Reset takes priority over every other event, including mid-CALC and mid-DONE.
  - An in-flight operation is dropped with no result produced.
- FSM: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - At an edge with in_valid=1: latch dividend and divisor.
  - If divisor==0 -> DONE, with quotient=all-ones, remainder=dividend[DIVW-1:0] (truncated), div_by_zero=1.
  - Otherwise -> CALC with step counter=0, partial remainder (DIVW+1 bits)=0, div_by_zero=0.
- CALC:
  - in_ready=0.
  - One restoring step per edge, processing the dividend MSB first:
    - shift the next dividend bit into the partial remainder;
    - trial-subtract the divisor;
    - if the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set it to 0.
  - After the WIDTH-th step -> DONE, with quotient and remainder registered.
  - Invariant: dividend == quotient*divisor + remainder, and remainder < divisor.
- DONE:
  - out_valid=1, in_ready=0.
  - quotient, remainder and div_by_zero hold stable while out_ready=0 (arbitrarily long).
  - At an edge with out_ready=1 -> IDLE; out_valid=0 and in_ready=1 from the next cycle.
  - The result registers keep their last values after the handshake.
- Latency, counted from the accepting edge:
  - Nonzero divisor: out_valid visible after exactly WIDTH further edges.
  - Zero divisor: out_valid visible after 1 edge.
  - Minimum turnaround is one IDLE cycle between result handshake and the next acceptance (no overlap, no pipelining).
- Simultaneous events:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - in_valid and out_ready both high while in DONE: only the output handshake completes; the new operand is accepted in IDLE on a later edge.
- Edge operands:
  - dividend=0 gives quotient=0, remainder=0.
  - divisor=1 gives quotient=dividend, remainder=0.
  - dividend < divisor gives quotient=0, remainder=dividend.
  - The maximum operands (2^WIDTH-1 and 2^DIVW-1) must not overflow the partial remainder; this is why it is DIVW+1 bits.

Test Plan:
- 500/7, out_ready=1 -> out_valid exactly 9 edges after acceptance; quotient=71, remainder=3, div_by_zero=0; in_ready back to 1 the cycle after the handshake.
- Boundary operands (defaults):
  - 511/255 -> q=2, r=1.
  - 5/9 -> q=0, r=5.
  - 0/1 -> q=0, r=0.
  - 256/1 -> q=256, r=0.
- 300/0 -> out_valid after 1 edge; quotient=511, remainder=44 (300 truncated to 8 bits), div_by_zero=1. A following 10/3 -> q=3, r=1, div_by_zero=0.
- Back-pressure: 100/10, hold out_ready=0 for 6 cycles in DONE:
  - q=10, r=0 and out_valid stay stable;
  - in_valid pulsed meanwhile is not accepted (in_ready=0);
  - raise out_ready -> one handshake, then the pending operand is accepted from IDLE.
- Reset mid-operation: assert rst on the 4th CALC edge of 400/3:
  - next cycle state=IDLE, out_valid=0, outputs zero, in_ready=1;
  - no result is emitted;
  - a fresh 400/3 -> q=133, r=1.
- Randomized sweep of 2000 operand pairs with random out_ready stalls -> every result matches the reference model, and dividend==q*d+r holds.
